// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the RV32 pipeline. It holds the program counter
//   and issues word requests to instruction memory. In-order responses are
//   buffered in a 2-entry queue. One instruction per cycle is presented to
//   decode together with its PC. The canonical NOP is driven whenever no real
//   instruction is available.
//
//   Handshakes:
//     imem_req/imem_ready : a request transfers on a cycle where both are 1.
//                           imem_addr is stable while imem_req is high.
//     imem_rvalid         : one in-order response per cycle. There is no
//                           backpressure on it. The credit rule below ensures
//                           that a queue slot always exists for it.
//     fetch_valid/stall   : the head instruction is consumed on a cycle where
//                           fetch_valid=1 and stall=0.
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     stall                  decode cannot accept; hold the queue head
//     redirect_en/_pc        restart fetch at redirect_pc (word aligned)
//     imem_req/_addr/_ready  request channel to instruction memory
//     imem_rvalid/_rdata     response channel from instruction memory
//     ins_fetch_out          instruction to decode (NOP when not valid)
//     pc_fetch_out           PC of ins_fetch_out
//     fetch_valid            ins_fetch_out is a real instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins_fetch_out,
    output logic [31:0] pc_fetch_out,
    output logic        fetch_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  out_q, out_d;
    logic [1:0]  kill_q, kill_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;

    logic [31:0] q_pc_q  [2];
    logic [31:0] q_ins_q [2];

    logic [31:0] target;
    logic        pop;
    logic        accept;
    logic        rsp;
    logic        push;
    logic [2:0]  credit_used;
    logic [2:0]  credit_lim;

    assign target = {redirect_pc[31:2], 2'b00};

    assign fetch_valid = !rst && !redirect_en && (count_q != 2'd0);
    assign pop         = fetch_valid && !stall;

    // Queue slots plus in-flight requests never exceed 2. A slot freed by a
    // pop this cycle may already be spent on a new request.
    assign credit_used = {1'b0, count_q} + {1'b0, out_q};
    assign credit_lim  = 3'd2 + {2'b00, pop};
    assign imem_req    = !rst && !redirect_en && (credit_used < credit_lim);
    assign accept      = imem_req && imem_ready;

    // A response with nothing outstanding is stale (e.g. after a reset).
    assign rsp  = imem_rvalid && (out_q != 2'd0);
    assign push = !rst && !redirect_en && rsp && (kill_q == 2'd0);

    assign imem_addr     = rst ? RESET_PC : pc_q;
    assign ins_fetch_out = fetch_valid ? q_ins_q[rd_ptr_q] : NOP;
    assign pc_fetch_out  = fetch_valid ? q_pc_q[rd_ptr_q]
                                       : (rst ? RESET_PC : resp_pc_q);

    always_comb begin
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        count_d   = count_q;
        out_d     = out_q;
        kill_d    = kill_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;

        if (redirect_en) begin
            // No request goes out this cycle, so only a response can change
            // the in-flight count. Everything still in flight must be killed.
            pc_d      = target;
            resp_pc_d = target;
            count_d   = 2'd0;
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            out_d     = out_q - {1'b0, rsp};
            kill_d    = out_q - {1'b0, rsp};
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            out_d = out_q + {1'b0, accept} - {1'b0, rsp};
            if (rsp && (kill_q != 2'd0)) begin
                kill_d = kill_q - 2'd1;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + 32'd4;
                wr_ptr_d  = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            count_q   <= 2'd0;
            out_q     <= 2'd0;
            kill_q    <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            count_q   <= count_d;
            out_q     <= out_d;
            kill_q    <= kill_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Queue storage carries no control meaning, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc_q[wr_ptr_q]  <= resp_pc_q;
            q_ins_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32 pipeline, directly upstream of the decode stage. Holds the program counter, issues word requests to instruction memory over a request/ready handshake, and buffers in-order responses in a 2-entry queue. Presents one instruction per cycle, with its PC, to decode. Injects the canonical NOP (`addi x0,x0,0`) whenever no valid instruction is available, on reset, and on a redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0013, instruction driven when `fetch_valid`=0
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  decode cannot accept; hold queue head
- redirect_en  in  1  branch/jump taken; restart fetch at `redirect_pc`
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req  out  1  request valid
- imem_addr  out  32  request word address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  one in-order response this cycle
- imem_rdata  in  32  response instruction word
- ins_fetch_out  out  32  instruction to decode (`ins_dec_in`)
- pc_fetch_out  out  32  PC of `ins_fetch_out`
- fetch_valid  out  1  `ins_fetch_out` is a real instruction

Clock and reset: one clock; reset is synchronous and active-high. Ports are named `clk` and `rst`.

## Operation
- State registers:
  - `pc`: next request address.
  - `resp_pc`: PC of the next kept response.
  - Queue: 2 entries of {pc, instr}, with `count` 0..2.
  - `outstanding`: accepted requests not yet answered, 0..2.
  - `kill`: outstanding responses to discard, 0..2.
- Accept = `imem_req && imem_ready`. On accept, `pc <= pc+4` (wraps modulo 2^32) and `outstanding` increments.
- `pop` = `fetch_valid && !stall`.
- `imem_req` = `!rst && !redirect_en && (count + outstanding < 2 + pop)`.
  - This credit rule guarantees every response has a queue slot.
  - `pop` feeds `imem_req` combinationally.
- On a response (`imem_rvalid` with `outstanding`>0), `outstanding` decrements.
  - If `kill`>0: the data is dropped and `kill` decrements.
  - Otherwise: {resp_pc, imem_rdata} is pushed and `resp_pc <= resp_pc+4`.
- `imem_rvalid` while `outstanding`==0 is ignored. This covers stale responses after a reset.
- Accept and response in the same cycle leave `outstanding` unchanged. Push and pop in the same cycle leave `count` unchanged.
- Output path (combinational from the queue head):
  - When `count`>0 and `!redirect_en`: `fetch_valid`=1, and head {pc, instr} drives `pc_fetch_out` and `ins_fetch_out`.
  - Otherwise: `fetch_valid`=0, `ins_fetch_out`=NOP, `pc_fetch_out`=`resp_pc`.
- Redirect (`redirect_en`=1), in priority over stall and pop:
  - Queue is flushed (`count <= 0`).
  - `pc` and `resp_pc` are loaded with {redirect_pc[31:2], 2'b00}.
  - No request is issued that cycle.
  - `kill <= outstanding_next`, where outstanding_next is `outstanding` minus any response arriving that cycle. Any response data arriving that cycle is dropped.
- Back-to-back redirects recompute `kill` the same way. Earlier kills are already contained in `outstanding`.
- Stall holds the head, and the credit rule throttles requests. No response is ever lost.

## Timing
- Reset, in effect on the edge where `rst`=1:
  - Registers: `pc`=`resp_pc`=RESET_PC, `count`=`outstanding`=`kill`=0.
  - Outputs while `rst` is high: `imem_req`=0, `imem_addr`=RESET_PC, `fetch_valid`=0, `ins_fetch_out`=NOP, `pc_fetch_out`=RESET_PC.
- Reset mid-operation discards the queue and all in-flight state in one cycle.
- First request is at the first cycle with `rst`=0.
- Latency:
  - Accept at cycle t; memory responds at t+L (L≥1).
  - The instruction is visible at the output at t+L+1.
  - Decode latches it at the end of that cycle.
- Throughput with L=1 and no stall: one instruction per cycle once primed. The first instruction appears 2 cycles after reset release.
- Redirect at cycle r:
  - The first request to the target is issued at r+1.
  - With L=1, the target instruction is at the output at r+3.
  - `fetch_valid`=0 from r through r+2.
- With full queue (`count`=2) and stall: `imem_req`=0 and `outstanding`=0.

## Test plan
- Reset release, memory with L=1 and ready always high:
  - `imem_addr` = 0x0, 0x4, 0x8 on consecutive cycles.
  - `fetch_valid` rises 2 cycles after release.
  - `pc_fetch_out` = 0x0, 0x4, 0x8 with the matching `imem_rdata` words.
- Stall high for 4 cycles while streaming:
  - The head stays constant.
  - `imem_req` drops once `count` + `outstanding` = 2.
  - After release, the next PCs continue with no gap or duplicate.
- `redirect_en` with `redirect_pc`=0x103 while 2 requests are outstanding:
  - Both stale responses are dropped.
  - The next valid output is pc 0x100.
  - NOP is driven during the gap.
- `imem_ready` toggling every other cycle:
  - Addresses advance only on accept.
  - Output PCs are strictly sequential by +4.
- `rst` asserted mid-stream with a response arriving in the cycle after release:
  - That stray `imem_rvalid` is ignored.
  - Fetch restarts at RESET_PC.
- `pc` at 0xFFFF_FFFC:
  - The next request wraps to 0x0000_0000.
  - `pc_fetch_out` follows.
